// File: rtl/pwla_act_pipe_if.sv
// Sample stream bundle between the MAC array, the activation pipe and layer writeback.
// Upstream side is in_*, downstream side is out_*; sat_count rides along as status.
interface pwla_act_pipe_if #(
   parameter int DATA_W = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic              in_mode;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_y;
   logic [15:0]       sat_count;

   modport slave (
      input  in_valid, in_x, in_mode, out_ready,
      output in_ready, out_valid, out_y, sat_count
   );

   modport master (
      output in_valid, in_x, in_mode, out_ready,
      input  in_ready, out_valid, out_y, sat_count
   );
endinterface

// File: rtl/pwla_act_pipe.sv
// PLAN piecewise-linear sigmoid/tanh, signed Q(FRAC_W); PWLA_SAT_CNT_EN adds a saturation counter.
// Latency 3 cycles (S1 magnitude, S2 segment, S3 symmetry), 1 sample/cycle.
// Full backpressure: each stage holds when the next is stalled; in_ready is combinational from out_ready.
module pwla_act_pipe #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10
) (
   input  logic            clk,
   input  logic            reset_n,
   pwla_act_pipe_if.slave  bus
);

   localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] U       = DATA_W'(1 << FRAC_W);
   localparam logic [DATA_W-1:0] T_SAT   = DATA_W'(5 << FRAC_W);
   localparam logic [DATA_W-1:0] T_HI    = DATA_W'(19 << (FRAC_W - 3));
   localparam logic [DATA_W-1:0] OFF_HI  = DATA_W'(27 << (FRAC_W - 5));
   localparam logic [DATA_W-1:0] OFF_MID = DATA_W'(5 << (FRAC_W - 3));
   localparam logic [DATA_W-1:0] OFF_LO  = DATA_W'(1 << (FRAC_W - 1));

   logic              s1_vld, s2_vld, s3_vld;
   logic              s1_adv, s2_adv, s3_adv;
   logic              in_xfer;

   logic              s1_neg, s1_mode;
   logic [DATA_W-1:0] s1_a;
   logic              s2_neg, s2_mode;
   logic [DATA_W-1:0] s2_y;
   logic [DATA_W-1:0] s3_y;

   logic              neg_c;
   logic [DATA_W-1:0] abs_c, mag_c;
   logic [DATA_W-1:0] y_c;
   logic [DATA_W-1:0] t_c, r_c;

   // Ready chain runs back from the output; a bubble anywhere lets upstream move.
   assign s3_adv  = !s3_vld || bus.out_ready;
   assign s2_adv  = s3_adv || !s2_vld;
   assign s1_adv  = s2_adv || !s1_vld;
   assign in_xfer = bus.in_valid && s1_adv;

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = s3_vld;
   assign bus.out_y     = s3_y;

   always_comb begin
      neg_c = bus.in_x[DATA_W-1];
      abs_c = bus.in_x;
      if (neg_c) begin
         abs_c = (bus.in_x == MIN_NEG) ? MAX_POS : -bus.in_x;
      end
      mag_c = abs_c;
      if (bus.in_mode) begin
         mag_c = abs_c[DATA_W-2] ? MAX_POS : {abs_c[DATA_W-2:0], 1'b0};
      end
   end

   always_comb begin
      if (s1_a >= T_SAT) begin
         y_c = U;
      end else if (s1_a >= T_HI) begin
         y_c = (s1_a >> 5) + OFF_HI;
      end else if (s1_a >= U) begin
         y_c = (s1_a >> 3) + OFF_MID;
      end else begin
         y_c = (s1_a >> 2) + OFF_LO;
      end
   end

   // Modulo-2^DATA_W arithmetic gives the same low bits as a DATA_W+1 intermediate.
   always_comb begin
      t_c = {s2_y[DATA_W-2:0], 1'b0} - U;
      if (s2_mode) begin
         r_c = s2_neg ? -t_c : t_c;
      end else begin
         r_c = s2_neg ? (U - s2_y) : s2_y;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld  <= 1'b0;
         s1_neg  <= 1'b0;
         s1_mode <= 1'b0;
         s1_a    <= '0;
         s2_vld  <= 1'b0;
         s2_neg  <= 1'b0;
         s2_mode <= 1'b0;
         s2_y    <= '0;
         s3_vld  <= 1'b0;
         s3_y    <= '0;
      end else begin
         if (s1_adv) begin
            s1_vld <= bus.in_valid;
         end
         if (in_xfer) begin
            s1_neg  <= neg_c;
            s1_mode <= bus.in_mode;
            s1_a    <= mag_c;
         end
         if (s2_adv) begin
            s2_vld <= s1_vld;
         end
         if (s2_adv && s1_vld) begin
            s2_neg  <= s1_neg;
            s2_mode <= s1_mode;
            s2_y    <= y_c;
         end
         if (s3_adv) begin
            s3_vld <= s2_vld;
         end
         if (s3_adv && s2_vld) begin
            s3_y <= r_c;
         end
      end
   end

`ifdef PWLA_SAT_CNT_EN
   logic        s2_sat, s3_sat;
   logic [15:0] sat_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_sat  <= 1'b0;
         s3_sat  <= 1'b0;
         sat_cnt <= '0;
      end else begin
         if (s2_adv && s1_vld) begin
            s2_sat <= (s1_a >= T_SAT);
         end
         if (s3_adv && s2_vld) begin
            s3_sat <= s2_sat;
         end
         // Counts only on an output handshake so stalled samples are not recounted.
         if (s3_vld && bus.out_ready && s3_sat && (sat_cnt != 16'hFFFF)) begin
            sat_cnt <= sat_cnt + 16'd1;
         end
      end
   end

   assign bus.sat_count = sat_cnt;
`else
   assign bus.sat_count = '0;
`endif

endmodule
